axis_pkt_m: RTL and testbench



---
 rtl/axis_pkt_m.sv | 127 ++++++++++++
 tb/tb_axis_pkt_m.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_m.sv
`default_nettype none
// ============================================================================
// Module   : axis_pkt_m
// Brief    : AXI-Stream packet master fed by a first-word-fall-through FIFO.
// Revision : 1.0
// ============================================================================
module axis_pkt_m #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int LEN_W  = 8
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     wr_en,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic [LEN_W-1:0]         len,
    input  logic                     send,
    output logic                     busy,
    input  logic                     tready,
    output logic                     tvalid,
    output logic [DATA_W-1:0]        tdata,
    output logic                     tlast,
    output logic                     finish
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              send_1d_q, send_1d_d;
    logic              overflow_q, overflow_d;
    logic              finish_q, finish_d;
    logic              empty;
    logic              push;
    logic              pop;
    logic              send_edge;

    // full comes from the registered count, so a same-cycle pop never frees a slot
    always_comb begin
        empty     = (count_q == '0);
        full      = (count_q == (AW+1)'(DEPTH));
        push      = wr_en & ~full;
        tvalid    = (state_q == S_SEND) & ~empty;
        pop       = tvalid & tready;
        tdata     = tvalid ? mem_q[rd_ptr_q] : '0;
        tlast     = tvalid & (rem_q == LEN_W'(1));
        busy      = (state_q == S_SEND);
        level     = count_q;
        overflow  = overflow_q;
        finish    = finish_q;
        send_edge = send & ~send_1d_q;
    end

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);
        overflow_d = overflow_q | (wr_en & full);
        send_1d_d  = send;
    end

    // Edges arriving while a packet is in flight are dropped, not queued
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        finish_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (send_edge && (len != '0)) begin
                    state_d = S_SEND;
                    rem_d   = len;
                end
            end
            S_SEND: begin
                if (pop) begin
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d  = S_IDLE;
                        finish_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rem_q      <= '0;
            send_1d_q  <= 1'b0;
            overflow_q <= 1'b0;
            finish_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rem_q      <= rem_d;
            send_1d_q  <= send_1d_d;
            overflow_q <= overflow_d;
            finish_q   <= finish_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_pkt_m.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_pkt_m
// Brief    : Scoreboard bench for axis_pkt_m.
// Revision : 1.0
// ============================================================================
module tb_axis_pkt_m;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int LEN_W  = 8;
    localparam int AW     = $clog2(DEPTH);

    logic              aclk = 1'b0;
    logic              areset = 1'b1;
    logic [DATA_W-1:0] wr_data = '0;
    logic              wr_en = 1'b0;
    logic              full;
    logic [AW:0]       level;
    logic              overflow;
    logic [LEN_W-1:0]  len = '0;
    logic              send = 1'b0;
    logic              busy;
    logic              tready = 1'b1;
    logic              tvalid;
    logic [DATA_W-1:0] tdata;
    logic              tlast;
    logic              finish;

    axis_pkt_m #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .aclk(aclk), .areset(areset), .wr_data(wr_data), .wr_en(wr_en),
        .full(full), .level(level), .overflow(overflow), .len(len),
        .send(send), .busy(busy), .tready(tready), .tvalid(tvalid),
        .tdata(tdata), .tlast(tlast), .finish(finish)
    );

    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_bad = 0;
    int hs_cnt = 0;
    int fin_cnt = 0;

    // Reference model: words pushed by stimulus, popped on each DUT handshake
    logic [DATA_W-1:0] mq [$];
    logic              m_busy = 1'b0;
    logic [LEN_W-1:0]  m_rem = '0;
    logic              m_fin = 1'b0;
    logic              m_ovf = 1'b0;
    logic              m_s1 = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    always @(negedge aclk) begin
        logic              e_tv;
        logic [DATA_W-1:0] e_data;
        logic              hs;
        logic              was_full;
        logic              sedge;
        e_tv   = m_busy && (mq.size() != 0);
        e_data = '0;
        if (e_tv) e_data = mq[0];
        check("tvalid",   32'(tvalid),   32'(e_tv));
        check("tdata",    tdata,         e_data);
        check("tlast",    32'(tlast),    32'(e_tv && (m_rem == LEN_W'(1))));
        check("busy",     32'(busy),     32'(m_busy));
        check("level",    32'(level),    32'(mq.size()));
        check("full",     32'(full),     32'(mq.size() == DEPTH));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("finish",   32'(finish),   32'(m_fin));
        if (finish) fin_cnt++;
        if (areset) begin
            mq.delete();
            m_busy = 1'b0;
            m_rem  = '0;
            m_fin  = 1'b0;
            m_ovf  = 1'b0;
            m_s1   = 1'b0;
        end else begin
            hs = e_tv && tready;
            if (hs) hs_cnt++;
            m_fin    = hs && (m_rem == LEN_W'(1));
            was_full = (mq.size() == DEPTH);
            if (hs) void'(mq.pop_front());
            if (wr_en) begin
                if (was_full) m_ovf = 1'b1;
                else mq.push_back(wr_data);
            end
            sedge = send && !m_s1;
            m_s1  = send;
            if (m_busy) begin
                if (hs) begin
                    m_rem = m_rem - LEN_W'(1);
                    if (m_rem == '0) m_busy = 1'b0;
                end
            end else if (sedge && (len != '0)) begin
                m_busy = 1'b1;
                m_rem  = len;
            end
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic push(input logic [DATA_W-1:0] w);
        wr_en   = 1'b1;
        wr_data = w;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic send_pkt(input int n);
        len  = LEN_W'(n);
        send = 1'b1;
        tick();
        send = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && (m_busy || m_fin); i++) tick();
        tick();
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic basic_packet(input logic [DATA_W-1:0] base);
        int h0, f0;
        for (int i = 0; i < 4; i++) push(base + DATA_W'(i * 'h11));
        h0 = hs_cnt;
        f0 = fin_cnt;
        tready = 1'b1;
        send_pkt(4);
        wait_idle();
        check("pkt_hs", 32'(hs_cnt - h0), 32'd4);
        check("pkt_fin", 32'(fin_cnt - f0), 32'd1);
        check("pkt_level", 32'(level), 32'd0);
    endtask

    initial begin
        int h0, f0;
        logic [5:0] rdy_pat;
        tick();
        tick();
        areset = 1'b0;
        tick();

        // Four-beat packet at full throughput
        basic_packet(32'h11);

        // Three beats with back-pressure
        for (int i = 0; i < 3; i++) push(32'hB0 + DATA_W'(i));
        h0 = hs_cnt;
        rdy_pat = 6'b101001;
        tready = 1'b0;
        send_pkt(3);
        for (int i = 0; i < 6; i++) begin
            tready = rdy_pat[i];
            tick();
        end
        tready = 1'b1;
        wait_idle();
        check("bp_hs", 32'(hs_cnt - h0), 32'd3);

        // Packet longer than occupancy: underrun then refill
        push(32'hC0);
        push(32'hC1);
        h0 = hs_cnt;
        send_pkt(4);
        repeat (5) tick();
        check("under_hs", 32'(hs_cnt - h0), 32'd2);
        push(32'hC2);
        push(32'hC3);
        wait_idle();
        check("under_hs_all", 32'(hs_cnt - h0), 32'd4);

        // Overfill: the 17th word is lost
        for (int i = 0; i < DEPTH + 1; i++) push(32'hD00 + DATA_W'(i));
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_level", 32'(level), 32'(DEPTH));
        check("ovf_flag", 32'(overflow), 32'd1);
        h0 = hs_cnt;
        send_pkt(DEPTH);
        wait_idle();
        check("ovf_hs", 32'(hs_cnt - h0), 32'(DEPTH));
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Held send, edge while busy, zero-length request
        for (int i = 0; i < 6; i++) push(32'hE0 + DATA_W'(i));
        h0 = hs_cnt;
        f0 = fin_cnt;
        tready = 1'b0;
        len = 8'd3;
        send = 1'b1;
        repeat (20) tick();
        send = 1'b0;
        tick();
        send = 1'b1;
        tick();
        send = 1'b0;
        tready = 1'b1;
        wait_idle();
        len = '0;
        send = 1'b1;
        tick();
        send = 1'b0;
        repeat (4) tick();
        check("held_hs", 32'(hs_cnt - h0), 32'd3);
        check("held_fin", 32'(fin_cnt - f0), 32'd1);
        check("held_level", 32'(level), 32'd3);

        // Reset during beat two of a four-beat packet
        areset = 1'b1;
        tick();
        areset = 1'b0;
        for (int i = 0; i < 4; i++) push(32'hA1 + DATA_W'(i));
        f0 = fin_cnt;
        send_pkt(4);
        tick();
        areset = 1'b1;
        tick();
        areset = 1'b0;
        tick();
        check("rst_tvalid", 32'(tvalid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_fin", 32'(fin_cnt - f0), 32'd0);
        basic_packet(32'h55);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
